// File: rtl/enemy_formation_ctrl.sv
// Invader formation sequencer: marches an alive-bitmap grid, scans one ship per cycle for bullet hits.
// Latency: frame_i to MARCH in at most N+3 cycles; hit_o and mask clear 1 cycle after the matching compare.
// No backpressure: frame_i is dropped outside MARCH. ENEMY_SPEEDUP_EN shortens the step period as ships die.
module enemy_formation_ctrl #(
  parameter int rows_p            = 4,
  parameter int cols_p            = 8,
  parameter int ship_w_p          = 16,
  parameter int ship_h_p          = 12,
  parameter int gap_x_p           = 8,
  parameter int gap_y_p           = 8,
  parameter int left_start_p      = 64,
  parameter int top_start_p       = 40,
  parameter int step_px_p         = 4,
  parameter int drop_px_p         = 8,
  parameter int frames_per_step_p = 8,
  parameter int screen_w_p        = 640,
  parameter int land_y_p          = 429
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       frame_i,
  input  logic                       start_i,
  input  logic                       bullet_valid_i,
  input  logic [9:0]                 bullet_left_i,
  input  logic [9:0]                 bullet_right_i,
  input  logic [9:0]                 bullet_top_i,
  input  logic [9:0]                 bullet_bot_i,
  output logic [9:0]                 origin_x_o,
  output logic [9:0]                 origin_y_o,
  output logic [rows_p*cols_p-1:0]   alive_mask_o,
  output logic                       hit_o,
  output logic                       cleared_o,
  output logic                       landed_o,
  output logic [2:0]                 state_o
);

  localparam int N       = rows_p * cols_p;
  localparam int PITCH_X = ship_w_p + gap_x_p;
  localparam int PITCH_Y = ship_h_p + gap_y_p;
  localparam int IW      = (N > 1) ? $clog2(N) : 1;
  localparam int RW      = (rows_p > 1) ? $clog2(rows_p) : 1;
  localparam int CW      = (cols_p > 1) ? $clog2(cols_p) : 1;
  localparam int FW      = $clog2(frames_per_step_p + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MARCH   = 3'd1,
    SCAN    = 3'd2,
    STEP    = 3'd3,
    CHECK   = 3'd4,
    CLEARED = 3'd5,
    LANDED  = 3'd6
  } state_t;

  typedef struct packed {
    logic [9:0] left;
    logic [9:0] right;
    logic [9:0] top;
    logic [9:0] bot;
  } box_t;

  state_t          state_q, state_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [9:0]      ox_q, ox_d, oy_q, oy_d;
  logic            dir_left_q, dir_left_d;
  logic [FW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  box_t            box_q, box_d;
  logic            hit_q, hit_d, cleared_q, cleared_d, landed_q, landed_d;

  logic [cols_p-1:0] col_alive;
  logic [rows_p-1:0] row_alive;
  logic [CW-1:0]     right_col, left_col;
  logic [RW-1:0]     low_row;

  always_comb begin
    col_alive = '0;
    row_alive = '0;
    right_col = '0;
    left_col  = '0;
    low_row   = '0;
    for (int r = 0; r < rows_p; r++) begin
      for (int c = 0; c < cols_p; c++) begin
        if (mask_q[r*cols_p + c]) begin
          col_alive[c] = 1'b1;
          row_alive[r] = 1'b1;
        end
      end
    end
    for (int c = 0; c < cols_p; c++)
      if (col_alive[c]) right_col = CW'(c);
    for (int c = cols_p - 1; c >= 0; c--)
      if (col_alive[c]) left_col = CW'(c);
    for (int r = 0; r < rows_p; r++)
      if (row_alive[r]) low_row = RW'(r);
  end

  // Border and landing math in 11 bits so x + offset never wraps.
  logic [10:0] right_edge, left_edge, low_bot;
  logic [10:0] s_left, s_right, s_top, s_bot;
  logic        overlap, ship_hit;

  assign right_edge = {1'b0, ox_q} + 11'(right_col * PITCH_X) + 11'(ship_w_p);
  assign left_edge  = {1'b0, ox_q} + 11'(left_col * PITCH_X);
  assign low_bot    = {1'b0, oy_q} + 11'(low_row * PITCH_Y) + 11'(ship_h_p);

  assign s_left   = {1'b0, ox_q} + 11'(col_q * PITCH_X);
  assign s_right  = s_left + 11'(ship_w_p);
  assign s_top    = {1'b0, oy_q} + 11'(row_q * PITCH_Y);
  assign s_bot    = s_top + 11'(ship_h_p);
  assign overlap  = ({1'b0, box_q.left} < s_right) && ({1'b0, box_q.right} > s_left) &&
                    ({1'b0, box_q.top}  < s_bot)   && ({1'b0, box_q.bot}   > s_top);
  assign ship_hit = mask_q[idx_q] && overlap;

  logic [FW-1:0] period;
  logic          move_now;

`ifdef ENEMY_SPEEDUP_EN
  localparam int P_FULL = (frames_per_step_p > 0) ? frames_per_step_p : 1;
  localparam int P_HALF = (frames_per_step_p / 2 > 0) ? frames_per_step_p / 2 : 1;
  localparam int P_QTR  = (frames_per_step_p / 4 > 0) ? frames_per_step_p / 4 : 1;
  logic [IW:0] alive_cnt;

  always_comb begin
    alive_cnt = '0;
    for (int i = 0; i < N; i++)
      alive_cnt = alive_cnt + {{IW{1'b0}}, mask_q[i]};
    if (2 * int'(alive_cnt) > N)      period = FW'(P_FULL);
    else if (4 * int'(alive_cnt) > N) period = FW'(P_HALF);
    else                              period = FW'(P_QTR);
  end
`else
  assign period = FW'(frames_per_step_p);
`endif

  assign move_now = (cnt_q >= period - FW'(1));

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    dir_left_d = dir_left_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    row_d      = row_q;
    col_d      = col_q;
    box_d      = box_q;
    hit_d      = 1'b0;
    cleared_d  = cleared_q;
    landed_d   = landed_q;
    case (state_q)
      IDLE, CLEARED, LANDED: begin
        if (start_i) begin
          mask_d     = '1;
          ox_d       = 10'(left_start_p);
          oy_d       = 10'(top_start_p);
          dir_left_d = 1'b0;
          cnt_d      = '0;
          cleared_d  = 1'b0;
          landed_d   = 1'b0;
          state_d    = MARCH;
        end
      end
      MARCH: begin
        if (frame_i) begin
          if (bullet_valid_i) begin
            box_d   = '{bullet_left_i, bullet_right_i, bullet_top_i, bullet_bot_i};
            idx_d   = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = SCAN;
          end else begin
            state_d = STEP;
          end
        end
      end
      SCAN: begin
        if (ship_hit) begin
          mask_d[idx_q] = 1'b0;
          hit_d         = 1'b1;
          state_d       = STEP;
        end else if (idx_q == IW'(N - 1)) begin
          state_d = STEP;
        end else begin
          idx_d = idx_q + 1'b1;
          if (col_q == CW'(cols_p - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      STEP: begin
        state_d = CHECK;
        if (move_now) begin
          cnt_d = '0;
          // An empty grid has no edge; hold the origin until CHECK retires it.
          if (mask_q != '0) begin
            if (!dir_left_q) begin
              if (right_edge + 11'(step_px_p) > 11'(screen_w_p - 1)) begin
                oy_d       = oy_q + 10'(drop_px_p);
                dir_left_d = 1'b1;
              end else begin
                ox_d = ox_q + 10'(step_px_p);
              end
            end else begin
              if (left_edge < 11'(step_px_p)) begin
                oy_d       = oy_q + 10'(drop_px_p);
                dir_left_d = 1'b0;
              end else begin
                ox_d = ox_q - 10'(step_px_p);
              end
            end
          end
        end else begin
          cnt_d = cnt_q + FW'(1);
        end
      end
      CHECK: begin
        if (mask_q == '0) begin
          state_d   = CLEARED;
          cleared_d = 1'b1;
        end else if (low_bot >= 11'(land_y_p)) begin
          state_d  = LANDED;
          landed_d = 1'b1;
        end else begin
          state_d = MARCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      mask_q     <= '1;
      ox_q       <= 10'(left_start_p);
      oy_q       <= 10'(top_start_p);
      dir_left_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      box_q      <= '0;
      hit_q      <= 1'b0;
      cleared_q  <= 1'b0;
      landed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      dir_left_q <= dir_left_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      box_q      <= box_d;
      hit_q      <= hit_d;
      cleared_q  <= cleared_d;
      landed_q   <= landed_d;
    end
  end

  assign origin_x_o   = ox_q;
  assign origin_y_o   = oy_q;
  assign alive_mask_o = mask_q;
  assign hit_o        = hit_q;
  assign cleared_o    = cleared_q;
  assign landed_o     = landed_q;
  assign state_o      = state_q;

endmodule

// File: doc/enemy_formation_ctrl.md
# enemy_formation_ctrl

Sequencer for the invader formation. Holds a rows×cols grid of enemy ships as an alive bitmap plus one shared origin. On frame ticks it marches the grid: steps sideways, drops and reverses at the screen border, and detects landing. Once per frame it serially scans the player bullet against every live ship and retires the first one hit. It sits between `player` (bullet box in, `hit_enemy_i` out) and the pixel painter, which derives ship areas from origin and bitmap.

## Interface
- `rows_p`, 4, formation rows
- `cols_p`, 8, formation columns; N = `rows_p*cols_p` ≤ 64
- `ship_w_p` / `ship_h_p`, 16 / 12, ship size in px
- `gap_x_p` / `gap_y_p`, 8 / 8, spacing; pitch_x = 24, pitch_y = 20
- `left_start_p` / `top_start_p`, 64 / 40, origin after reset/start
- `step_px_p`, 4, horizontal step
- `drop_px_p`, 8, vertical drop at border
- `frames_per_step_p`, 8, frames between steps
- `screen_w_p`, 640, visible width
- `land_y_p`, 429, landing line (player top)

Ports:
- `clk_i`  in  1  pixel clock
- `reset_n_i`  in  1  asynchronous, active-low reset
- `frame_i`  in  1  one-cycle frame tick
- `start_i`  in  1  synchronized start/restart
- `bullet_valid_i`  in  1  player bullet in flight
- `bullet_left_i`, `bullet_right_i`, `bullet_top_i`, `bullet_bot_i`  in  10 each  bullet box
- `origin_x_o`, `origin_y_o`  out  10 each  top-left of ship (0,0)
- `alive_mask_o`  out  N  bit r*cols_p+c = ship (r,c) alive
- `hit_o`  out  1  one-cycle pulse per ship retired
- `cleared_o`  out  1  all ships dead
- `landed_o`  out  1  formation reached `land_y_p`
- `state_o`  out  3  FSM state for LEDs

## Operation
- Ship (r,c): left = ox + c·pitch_x, right = left + `ship_w_p`, top = oy + r·pitch_y, bot = top + `ship_h_p`.
- Overlap test: b_left < s_right, b_right > s_left, b_top < s_bot and b_bot > s_top.
- States: IDLE=0, MARCH=1, SCAN=2, STEP=3, CHECK=4, CLEARED=5, LANDED=6.
- IDLE / CLEARED / LANDED on `start_i`:
  - mask all ones, origin at start values, dir = right, frame counter = 0
  - clear `cleared_o` and `landed_o`, enter MARCH
- MARCH on `frame_i`: if `bullet_valid_i`, snapshot the bullet box, index = 0, enter SCAN; otherwise enter STEP.
- SCAN: one ship per cycle, in index order.
  - First live, overlapping ship: clear its mask bit, pulse `hit_o`, enter STEP. At most one hit per frame.
  - Index N-1 reached with no hit: enter STEP.
- STEP: counter increments. When it reaches the period − 1, the counter zeroes and the formation moves:
  - Edge = rightmost alive column's right when dir = right, leftmost alive column's left when dir = left.
  - If edge ± `step_px_p` leaves [0, `screen_w_p`−1]: oy += `drop_px_p`, dir flips, ox unchanged.
  - Otherwise ox ± `step_px_p`.
- CHECK:
  - mask == 0: CLEARED, `cleared_o` = 1.
  - Else if bottom of lowest alive row ≥ `land_y_p`: LANDED, `landed_o` = 1.
  - Else: MARCH.
- `frame_i` outside MARCH is ignored. `start_i` in MARCH/SCAN/STEP/CHECK is ignored.
- Arithmetic: 10-bit unsigned. Border math is done in 11 bits so the sum never wraps.

## Timing
- Reset values: state IDLE, mask all ones, origin (`left_start_p`, `top_start_p`), dir right, counter 0. `hit_o`, `cleared_o` and `landed_o` are 0.
- Reset is asynchronous and takes effect in any state, including mid-SCAN. `hit_o` drops immediately.
- All outputs are registered.
- Frame latency: `frame_i` → SCAN/STEP on the next edge.
  - SCAN lasts k+1 cycles (k = index of the hit ship, or N−1 if none).
  - STEP and CHECK last 1 cycle each.
  - Worst case, `frame_i` → MARCH is N+3 cycles, far below the frame period.
- Hit: `hit_o` and the mask-bit clear appear together, 1 cycle after the matching compare.
- The origin updates on leaving STEP. Status flags update on leaving CHECK.

## Configuration
- `ENEMY_SPEEDUP_EN` defined: the step period depends on the alive count.
  - Alive > N/2: `frames_per_step_p`.
  - Alive ≤ N/2: half of it.
  - Alive ≤ N/4: a quarter of it.
  - Minimum 1 frame in every case.
- Not defined: the period is always `frames_per_step_p`. The popcount logic is absent.

## Test plan
- Reset, no stimulus → state 0, mask 0xFFFFFFFF, origin (64,40), `hit_o`/`cleared_o`/`landed_o` = 0.
- `start_i`, then 8 `frame_i` with no bullet → origin_x 68 after the 8th frame, origin_y 40, state returns to 1.
- MARCH, box (70,74,45,55) valid, `frame_i` → one `hit_o` pulse, mask 0xFFFFFFFE. Repeat the same box → no pulse (ship 0 dead, ship 1 spans 88..104).
- `frames_per_step_p`=1: march right until rightmost edge + 4 > 639 → that step gives oy +8 with ox held; the following step gives ox −4.
- Retire all 32 ships → `cleared_o` = 1, state 5, `frame_i` ignored. `start_i` → mask restored, state 1.
- `reset_n_i` low during SCAN at index 10 → state 0, `hit_o` 0, mask all ones without waiting for a clock edge.
